// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a boot image as a byte stream
// (LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO}, CHK), assembles big-endian
// 16-bit words, writes them into instruction memory starting at BASE_ADDR,
// and holds the CPU stalled until the whole image is in and the XOR
// checksum over all data bytes matches.
module imem_boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        instruction_write,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  // Length limit widened by one bit so lengths up to 0xFFFF compare cleanly.
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [7:0]  word_hi;
  logic        xfer;
  logic [15:0] len_next;

  // Byte acceptance is a pure decode of the state register.
  assign rx_ready = (state == S_LEN_HI)  || (state == S_LEN_LO) ||
                    (state == S_DATA_HI) || (state == S_DATA_LO) ||
                    (state == S_CHK);
  assign xfer     = rx_valid & rx_ready;
  assign len_next = {len[15:8], rx_data};

  // Upper data byte is held until its low byte arrives; it needs no reset
  // because it is only consumed after being written in DATA_HI.
  always_ff @(posedge clk) begin
    if (state == S_DATA_HI && xfer) begin
      word_hi <= rx_data;
    end
  end

  // Load sequencer with registered memory-side and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      len               <= 16'd0;
      csum              <= 8'd0;
      instruction_in    <= 16'd0;
      load_address      <= 16'd0;
      instruction_write <= 1'b0;
      cpu_hold          <= 1'b1;
      load_done         <= 1'b0;
      load_error        <= 1'b0;
      words_loaded      <= 16'd0;
    end else begin
      instruction_write <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            words_loaded <= 16'd0;
            csum         <= 8'd0;
            cpu_hold     <= 1'b1;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= rx_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= rx_data;
            if (len_next == 16'd0 || {1'b0, len_next} > MAX_LEN) begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            csum  <= csum ^ rx_data;
            state <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          // Strobe and address/data are registered here so they are
          // presented for exactly the single WRITE cycle.
          if (xfer) begin
            csum              <= csum ^ rx_data;
            instruction_in    <= {word_hi, rx_data};
            load_address      <= BASE_ADDR + words_loaded;
            instruction_write <= 1'b1;
            state             <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          if (words_loaded + 16'd1 == len) begin
            state <= S_CHK;
          end else begin
            state <= S_DATA_HI;
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (rx_data == csum) begin
              state     <= S_DONE;
              cpu_hold  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state      <= S_ERROR;
              load_error <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised self-checking bench for imem_boot_loader. A reference model
// derives the expected memory writes and final status from the image
// contents (length rules and XOR of all data bytes).
module tb_imem_boot_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] instruction_in;
  logic [15:0] load_address;
  logic        instruction_write;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] img[$];
  logic [31:0] wq[$];

  imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready),
    .instruction_in    (instruction_in),
    .load_address      (load_address),
    .instruction_write (instruction_write),
    .cpu_hold          (cpu_hold),
    .load_done         (load_done),
    .load_error        (load_error),
    .words_loaded      (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Write monitor: records every strobe cycle; the loader must not accept
  // bytes while it is writing.
  always @(negedge clk) begin
    if (rst_n && instruction_write) begin
      wq.push_back({load_address, instruction_in});
      chk_eq("rdy_in_write", 32'(rx_ready), 32'd0);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offer one byte (optionally after random idle cycles) and return at the
  // negedge following its acceptance.
  task automatic send_byte(input logic [7:0] b, input bit bp);
    int n;
    n = 0;
    if (bp) begin
      while ($urandom_range(0, 1) == 1) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk_eq("byte_accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Run a complete load of img[] with header length n and checksum byte c,
  // then compare the recorded writes and status against the model.
  task automatic run_load(input logic [15:0] n, input logic [7:0] c,
                          input bit bp, input bit mid_start, input string tag);
    bit          ok_len;
    bit          exp_ok;
    logic [7:0]  cs;
    int          nexp;
    ok_len = (n != 16'd0) && (int'(n) <= MAXW);
    nexp   = ok_len ? int'(n) : 0;
    cs     = 8'd0;
    for (int i = 0; i < nexp; i++) cs = cs ^ img[i][15:8] ^ img[i][7:0];
    exp_ok = ok_len && (c == cs);
    wq.delete();

    pulse_start();
    chk_eq({tag, "_hold_after_start"}, 32'(cpu_hold), 32'd1);
    chk_eq({tag, "_done_after_start"}, 32'(load_done), 32'd0);
    chk_eq({tag, "_err_after_start"}, 32'(load_error), 32'd0);

    send_byte(n[15:8], bp);
    send_byte(n[7:0], bp);
    if (ok_len) begin
      for (int i = 0; i < nexp; i++) begin
        if (mid_start && i == 0) pulse_start();
        send_byte(img[i][15:8], bp);
        send_byte(img[i][7:0], bp);
      end
      send_byte(c, bp);
    end
    @(negedge clk);

    chk_eq({tag, "_nwrites"}, 32'(wq.size()), 32'(nexp));
    for (int i = 0; i < wq.size() && i < nexp; i++) begin
      chk_eq({tag, "_wr"}, wq[i], {BASE + 16'(i), img[i]});
    end
    chk_eq({tag, "_done"}, 32'(load_done), 32'(exp_ok));
    chk_eq({tag, "_error"}, 32'(load_error), 32'(!exp_ok));
    chk_eq({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_ok));
    chk_eq({tag, "_words"}, 32'(words_loaded), 32'(nexp));
    chk_eq({tag, "_rdy_idle"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    logic [7:0] cs;
    logic [15:0] n;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk_eq("rst_hold", 32'(cpu_hold), 32'd1);
    chk_eq("rst_write", 32'(instruction_write), 32'd0);
    chk_eq("rst_ready", 32'(rx_ready), 32'd0);
    chk_eq("rst_done", 32'(load_done), 32'd0);
    chk_eq("rst_error", 32'(load_error), 32'd0);
    chk_eq("rst_words", 32'(words_loaded), 32'd0);
    chk_eq("rst_addr", 32'(load_address), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("idle_ready", 32'(rx_ready), 32'd0);

    // Reset asserted while waiting for DATA_LO.
    wq.delete();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    chk_eq("t1_in_data_lo_ready", 32'(rx_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t1_hold", 32'(cpu_hold), 32'd1);
    chk_eq("t1_write", 32'(instruction_write), 32'd0);
    chk_eq("t1_ready", 32'(rx_ready), 32'd0);
    chk_eq("t1_done", 32'(load_done), 32'd0);
    chk_eq("t1_error", 32'(load_error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    repeat (4) @(negedge clk);
    rx_valid = 1'b0;
    chk_eq("t1_stays_idle", 32'(rx_ready), 32'd0);
    chk_eq("t1_no_writes", 32'(wq.size()), 32'd0);
    chk_eq("t1_hold_after", 32'(cpu_hold), 32'd1);

    // Nominal two-word image, then bad checksum.
    img = '{16'h1234, 16'hABCD};
    run_load(16'd2, 8'h40, 1'b0, 1'b0, "t2");
    run_load(16'd2, 8'h41, 1'b0, 1'b0, "t3");

    // Length bounds.
    img.delete();
    run_load(16'd0, 8'h00, 1'b0, 1'b0, "t4_zero");
    run_load(16'(MAXW + 1), 8'h00, 1'b0, 1'b0, "t4_over");
    run_load(16'hFF00, 8'h00, 1'b0, 1'b0, "t4_huge");
    img.delete();
    cs = 8'd0;
    for (int i = 0; i < MAXW; i++) begin
      img.push_back(16'($urandom));
      cs = cs ^ img[i][15:8] ^ img[i][7:0];
    end
    run_load(16'(MAXW), cs, 1'b0, 1'b0, "t4_max");
    if (wq.size() > 0) chk_eq("t4_last_addr", 32'(wq[wq.size()-1][31:16]), 32'(BASE + 16'(MAXW - 1)));

    // Backpressure on the nominal image.
    img = '{16'h1234, 16'hABCD};
    run_load(16'd2, 8'h40, 1'b1, 1'b0, "t5");

    // Restart from DONE, with an ignored start during DATA_HI.
    img = '{16'hBEEF};
    run_load(16'd1, 8'h51, 1'b0, 1'b1, "t6");

    // Random images with random backpressure; some checksums corrupted.
    for (int k = 0; k < 8; k++) begin
      n = 16'($urandom_range(1, MAXW));
      img.delete();
      cs = 8'd0;
      for (int i = 0; i < int'(n); i++) begin
        img.push_back(16'($urandom));
        cs = cs ^ img[i][15:8] ^ img[i][7:0];
      end
      if ($urandom_range(0, 2) == 0) cs = cs ^ (8'd1 << $urandom_range(0, 7));
      run_load(n, cs, 1'b1, ($urandom_range(0, 1) == 1), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
